// File: rtl/ram_seq_pkg.sv
// Shared encodings for the RAM access sequencer: command codes, FSM states,
// default widths and the depth of the attached 32x4 RAM.
package ram_seq_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 4;
  localparam int RAM_DEPTH  = 32;

  typedef enum logic [1:0] {
    CMD_WRITE = 2'b00,
    CMD_READ  = 2'b01,
    CMD_FILL  = 2'b10,
    CMD_SCAN  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_RD_WAIT   = 3'd2,
    ST_RD_CAP    = 3'd3,
    ST_FILL      = 3'd4,
    ST_SCAN_WAIT = 3'd5,
    ST_SCAN_HOLD = 3'd6,
    ST_FINISH    = 3'd7
  } state_e;

endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter that times how long each scanned word stays on
// display. tc marks the last enabled cycle of a dwell period.
module dwell_counter #(
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reload on a new word, otherwise count down while holding, stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(DWELL_CYCLES);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tc = en && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ram_access_sequencer.sv
// Turns user requests (WRITE, READ, FILL, SCAN) into correctly timed cycles
// for a synchronous 32-word RAM and presents read results to the display.
//
// Handshake: a rising edge of go while busy is low (and abort is low) starts
// a command; busy stays high from the accept edge until done falls; done
// pulses for one cycle on normal completion only; rd_valid pulses for one
// cycle whenever rd_addr/rd_data take a new word. Starts while busy are lost.
module ram_access_sequencer
  import ram_seq_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int RD_LATENCY   = 1,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              go,
  input  logic              abort,
  input  logic [1:0]        cmd,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output state_e            dbg_state
);

  localparam int WAIT_W = (RD_LATENCY < 1) ? 1 : $clog2(RD_LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LATENCY);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  state_e            state_q, state_d;
  logic              go_sync_q, go_sync_d, go_prev_q, go_prev_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d, rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d, rd_data_q, rd_data_d;
  logic              ram_wren_q, ram_wren_d, rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              start, dwell_load, dwell_tc;

  // Edge detector on the registered go level.
  always_comb begin
    go_sync_d = go;
    go_prev_d = go_sync_q;
  end
  assign start = go_sync_q && !go_prev_q;

  dwell_counter #(.DWELL_CYCLES(DWELL_CYCLES)) u_dwell (
    .clk    (clk),
    .resetn (resetn),
    .load   (dwell_load),
    .en     (state_q == ST_SCAN_HOLD),
    .tc     (dwell_tc)
  );

  // State and output registers; reset abandons any command at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      go_sync_q  <= 1'b0;
      go_prev_q  <= 1'b0;
      wait_cnt_q <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wren_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      go_sync_q  <= go_sync_d;
      go_prev_q  <= go_prev_d;
      wait_cnt_q <= wait_cnt_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_wren_q <= ram_wren_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; abort from any active state wins over everything.
  always_comb begin
    state_d = state_q;
    if ((state_q != ST_IDLE) && abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            case (cmd_e'(cmd))
              CMD_WRITE: state_d = ST_WRITE;
              CMD_READ:  state_d = ST_RD_WAIT;
              CMD_FILL:  state_d = ST_FILL;
              default:   state_d = ST_SCAN_WAIT;
            endcase
          end
        end
        ST_WRITE:     state_d = ST_FINISH;
        ST_RD_WAIT:   if (wait_cnt_q == WAIT_LAST) state_d = ST_RD_CAP;
        ST_RD_CAP:    state_d = ST_FINISH;
        ST_FILL:      if (ram_addr_q == LAST_ADDR) state_d = ST_FINISH;
        ST_SCAN_WAIT: if (wait_cnt_q == WAIT_LAST) state_d = ST_SCAN_HOLD;
        ST_SCAN_HOLD: begin
          if (dwell_tc) state_d = (ram_addr_q == LAST_ADDR) ? ST_FINISH : ST_SCAN_WAIT;
        end
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Output/datapath logic: RAM drive, read capture, wait counting.
  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_wren_d = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wait_cnt_d = wait_cnt_q;
    dwell_load = 1'b0;
    if (state_d != ST_IDLE) begin
      case (state_q)
        ST_IDLE: begin
          wait_cnt_d = '0;
          case (state_d)
            ST_WRITE: begin
              ram_addr_d = addr_in;
              ram_data_d = data_in;
              ram_wren_d = 1'b1;
            end
            ST_RD_WAIT: ram_addr_d = addr_in;
            ST_FILL: begin
              ram_addr_d = '0;
              ram_data_d = data_in;
              ram_wren_d = 1'b1;
            end
            ST_SCAN_WAIT: ram_addr_d = '0;
            default: ;
          endcase
        end
        ST_RD_WAIT, ST_SCAN_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            rd_data_d  = ram_q;
            rd_addr_d  = ram_addr_q;
            rd_valid_d = 1'b1;
            dwell_load = (state_q == ST_SCAN_WAIT);
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
        ST_FILL: begin
          if (state_d == ST_FILL) begin
            ram_addr_d = ram_addr_q + ADDR_W'(1);
            ram_wren_d = 1'b1;
          end
        end
        ST_SCAN_HOLD: begin
          if (state_d == ST_SCAN_WAIT) begin
            ram_addr_d = ram_addr_q + ADDR_W'(1);
            wait_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FINISH);
  end

  assign ram_addr  = ram_addr_q;
  assign ram_data  = ram_data_q;
  assign ram_wren  = ram_wren_q;
  assign rd_addr   = rd_addr_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Bench for ram_access_sequencer with a behavioural 32x4 RAM, RD_LATENCY=1
// and DWELL_CYCLES=4. A command-level model predicts RAM writes, read
// results, done pulses and the busy window; one negedge process compares.
module tb_ram_access_sequencer;
  import ram_seq_pkg::*;

  localparam int RL    = 1;
  localparam int DWELL = 4;
  localparam int STEP  = RL + 1 + DWELL;
  localparam int SCAN_LEN = (RL + 1) + 31 * STEP + DWELL;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic go = 1'b0, abort = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [4:0] addr_in = '0;
  logic [3:0] data_in = '0;
  logic [4:0] ram_addr, rd_addr;
  logic [3:0] ram_data, rd_data, ram_q;
  logic ram_wren, rd_valid, busy, done;
  state_e dbg_state;

  always #5 clk = ~clk;

  ram_access_sequencer #(
    .ADDR_W(5), .DATA_W(4), .RD_LATENCY(RL), .DWELL_CYCLES(DWELL)
  ) dut (
    .clk(clk), .resetn(resetn), .go(go), .abort(abort), .cmd(cmd),
    .addr_in(addr_in), .data_in(data_in), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Behavioural ram32x4: registered address, one cycle to q.
  logic [3:0] ram_mem [32];
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_addr] <= ram_data;
    ram_q <= ram_mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model / scoreboard ----------------
  logic [24:0] exp_wr_q[$];
  logic [24:0] exp_rd_q[$];
  logic [24:0] exp_done_q[$];
  logic [3:0]  mdl_mem [32];
  int busy_lo = -1, busy_hi = -2;
  int n_cmp = 0, n_bad = 0;
  logic chk_en = 1'b0;

  function automatic logic [24:0] ev(input int c, input logic [4:0] a, input logic [3:0] d);
    logic [31:0] cc;
    cc = c;
    return {cc[15:0], a, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Per-cycle compare against the model's event queues.
  always @(negedge clk) begin
    logic hit;
    logic [24:0] cur;
    if (chk_en) begin
      n_cmp++;
      if (busy !== ((cyc >= busy_lo) && (cyc <= busy_hi))) begin
        n_bad++;
        $display("FAIL busy cyc=%0d: got %b required %b", cyc, busy, (cyc >= busy_lo) && (cyc <= busy_hi));
      end
      cur = ev(cyc, ram_addr, ram_data);
      hit = (exp_wr_q.size() > 0) && (exp_wr_q[0][24:9] == cur[24:9]);
      if (ram_wren || hit) begin
        n_cmp++;
        if (!hit || !ram_wren || (exp_wr_q[0] !== cur)) begin
          n_bad++;
          $display("FAIL ram_write cyc=%0d: got wren=%b ev=%h required %s", cyc, ram_wren, cur,
                   hit ? $sformatf("%h", exp_wr_q[0]) : "none");
        end
        if (hit) void'(exp_wr_q.pop_front());
      end
      cur = ev(cyc, rd_addr, rd_data);
      hit = (exp_rd_q.size() > 0) && (exp_rd_q[0][24:9] == cur[24:9]);
      if (rd_valid || hit) begin
        n_cmp++;
        if (!hit || !rd_valid || (exp_rd_q[0] !== cur)) begin
          n_bad++;
          $display("FAIL rd_valid cyc=%0d: got valid=%b ev=%h required %s", cyc, rd_valid, cur,
                   hit ? $sformatf("%h", exp_rd_q[0]) : "none");
        end
        if (hit) void'(exp_rd_q.pop_front());
      end
      cur = ev(cyc, 5'd0, 4'd0);
      hit = (exp_done_q.size() > 0) && (exp_done_q[0] == cur);
      if (done || hit) begin
        n_cmp++;
        if (!hit || !done) begin
          n_bad++;
          $display("FAIL done cyc=%0d: got %b required %b", cyc, done, hit);
        end
        if (hit) void'(exp_done_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Raise go; returns the clock edge (cycle number) that accepts it.
  task automatic issue(input logic [1:0] c, input logic [4:0] a, input logic [3:0] d, output int acc);
    @(negedge clk);
    cmd = c; addr_in = a; data_in = d; go = 1'b1;
    acc = cyc + 2;
  endtask

  // Change the command fields after acceptance; they must have no effect.
  task automatic scramble();
    cmd = 2'b10; addr_in = ~addr_in; data_in = ~data_in;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [3:0] d);
    int acc;
    issue(CMD_WRITE, a, d, acc);
    exp_wr_q.push_back(ev(acc, a, d));
    exp_done_q.push_back(ev(acc + 1, 5'd0, 4'd0));
    busy_lo = acc; busy_hi = acc + 1;
    mdl_mem[a] = d;
    wait_cyc(acc); scramble();
    wait_cyc(acc + 2); go = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, input int hold);
    int acc;
    issue(CMD_READ, a, 4'h0, acc);
    exp_rd_q.push_back(ev(acc + RL + 1, a, mdl_mem[a]));
    exp_done_q.push_back(ev(acc + RL + 2, 5'd0, 4'd0));
    busy_lo = acc; busy_hi = acc + RL + 2;
    wait_cyc(acc); scramble();
    wait_cyc(acc + ((hold > RL + 3) ? hold : RL + 3)); go = 1'b0;
  endtask

  task automatic do_fill(input logic [3:0] d);
    int acc;
    issue(CMD_FILL, 5'd0, d, acc);
    for (int i = 0; i < 32; i++) begin
      exp_wr_q.push_back(ev(acc + i, 5'(i), d));
      mdl_mem[i] = d;
    end
    exp_done_q.push_back(ev(acc + 32, 5'd0, 4'd0));
    busy_lo = acc; busy_hi = acc + 32;
    wait_cyc(acc); scramble();
    wait_cyc(acc + 33); go = 1'b0;
  endtask

  task automatic do_scan(input bit glitch);
    int acc;
    issue(CMD_SCAN, 5'd0, 4'h0, acc);
    for (int i = 0; i < 32; i++) exp_rd_q.push_back(ev(acc + RL + 1 + STEP * i, 5'(i), mdl_mem[i]));
    exp_done_q.push_back(ev(acc + SCAN_LEN, 5'd0, 4'd0));
    busy_lo = acc; busy_hi = acc + SCAN_LEN;
    wait_cyc(acc); scramble();
    if (glitch) begin
      wait_cyc(acc + 40); go = 1'b0;
      wait_cyc(acc + 42); go = 1'b1;
      wait_cyc(acc + 44); go = 1'b0;
    end
    wait_cyc(acc + SCAN_LEN + 1); go = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acc;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_wren", ram_wren, 0);
    chk("reset_ram_addr", ram_addr, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_state_idle", dbg_state, ST_IDLE);
    resetn = 1'b1;
    chk_en = 1'b1;

    // Preload with a recognisable pattern via WRITE commands.
    for (int i = 0; i < 32; i++) do_write(5'(i), 4'((i * 3 + 1) & 15));

    // WRITE then READ, with go held high for 100 cycles on the READ.
    do_write(5'd5, 4'hA);
    do_read(5'd5, 100);
    chk("wr_rd_data", rd_data, 4'hA);
    chk("wr_rd_addr", rd_addr, 5);

    // Reset in the middle of a FILL, while address 12 is presented.
    issue(CMD_FILL, 5'd0, 4'h9, acc);
    for (int i = 0; i < 12; i++) begin
      exp_wr_q.push_back(ev(acc + i, 5'(i), 4'h9));
      mdl_mem[i] = 4'h9;
    end
    busy_lo = acc; busy_hi = acc + 11;
    wait_cyc(acc + 11);
    @(posedge clk); #1;
    resetn = 1'b0; chk_en = 1'b0; go = 1'b0;
    #1;
    chk("mid_rst_wren", ram_wren, 0);
    chk("mid_rst_ram_addr", ram_addr, 0);
    chk("mid_rst_ram_data", ram_data, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    chk("mid_rst_rd_addr", rd_addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_writes_seen", exp_wr_q.size(), 0);
    busy_lo = -1; busy_hi = -2;
    repeat (2) @(negedge clk);
    resetn = 1'b1; chk_en = 1'b1;
    do_read(5'd13, 0);
    chk("rst_rd13_prefill", rd_data, 4'h8);
    do_read(5'd12, 0);
    chk("rst_rd12_prefill", rd_data, 4'h5);
    do_read(5'd11, 0);
    chk("rst_rd11_filled", rd_data, 4'h9);

    // FILL then SCAN reads the fill value everywhere.
    do_fill(4'h3);
    do_scan(1'b0);
    chk("fill_scan_data", rd_data, 4'h3);
    chk("fill_scan_addr", rd_addr, 31);

    // SCAN pacing over mem[i] = i mod 16, with an ignored go edge mid-scan.
    for (int i = 0; i < 32; i++) do_write(5'(i), 4'(i % 16));
    do_scan(1'b1);
    chk("scan_last_data", rd_data, 4'hF);
    chk("scan_last_addr", rd_addr, 31);

    // Abort during word 7's dwell.
    issue(CMD_SCAN, 5'd0, 4'h0, acc);
    for (int i = 0; i <= 7; i++) exp_rd_q.push_back(ev(acc + RL + 1 + STEP * i, 5'(i), mdl_mem[i]));
    busy_lo = acc; busy_hi = acc + 45;
    wait_cyc(acc + 45); abort = 1'b1;
    wait_cyc(acc + 46); abort = 1'b0; go = 1'b0;
    wait_cyc(acc + 52);
    chk("abort_rd_data", rd_data, 4'h7);
    chk("abort_rd_addr", rd_addr, 7);
    chk("abort_busy", busy, 0);

    // abort together with a go edge in IDLE: nothing may start.
    @(negedge clk); abort = 1'b1; go = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_go_busy", busy, 0);
    chk("abort_go_wren", ram_wren, 0);
    go = 1'b0; abort = 1'b0;
    do_read(5'd3, 0);
    chk("after_abort_rd3", rd_data, 4'h3);

    repeat (5) @(negedge clk);
    chk("wr_events_left", exp_wr_q.size(), 0);
    chk("rd_events_left", exp_rd_q.size(), 0);
    chk("done_events_left", exp_done_q.size(), 0);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
